// File: rtl/column_pkg.sv
// Shared types and constants for the LED column scheduler.
package column_pkg;

  localparam int unsigned NB_COLS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BLANK = 2'd2,
    DRIVE = 2'd3
  } sched_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/column_scheduler_cycle_timer.sv
// Loadable down-counter; done while the count sits at zero. Saturates, never wraps.
module cycle_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/column_scheduler.sv
// Per-slice column sequencer: request data, blank, then drive one column for a
// bounded time. A timed-out or overrun request spends one cycle with data_req low.
module column_scheduler
  import column_pkg::*;
#(
  parameter int unsigned NB_COLS      = NB_COLS_DEFAULT,
  parameter int unsigned DRIVE_CYCLES = 330,
  parameter int unsigned DEAD_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT  = 1023
) (
  input  logic                       clk_33,
  input  logic                       rst,
  input  logic                       framebuffer_sync,
  input  logic                       data_ack,
  output logic                       data_req,
  output logic [$clog2(NB_COLS)-1:0] col_idx,
  output logic [NB_COLS-1:0]         mux_out,
  output logic                       busy,
  output logic                       overrun,
  output logic                       ack_timeout
);

  localparam int unsigned COL_W    = $clog2(NB_COLS);
  localparam int unsigned CNT_W    = $clog2(max_u(DRIVE_CYCLES, ACK_TIMEOUT) + 1);
  localparam int unsigned LAST_COL = NB_COLS - 1;

  sched_state_e       r_state;
  logic [COL_W-1:0]   r_col;
  logic [NB_COLS-1:0] r_mux;
  logic               r_req;
  logic               r_busy;
  logic               r_overrun;
  logic               r_ack_timeout;

  logic               w_done;
  logic               w_last;
  logic               w_start;
  logic               w_overrun;
  logic               w_tmr_load;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tmr_dec;

  // A sync on the last column's final drive cycle is a clean back-to-back start.
  always_comb begin
    w_last     = (r_col == COL_W'(LAST_COL));
    w_start    = framebuffer_sync &&
                 ((r_state == IDLE) || ((r_state == DRIVE) && w_done && w_last));
    w_overrun  = framebuffer_sync && !w_start;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_dec  = 1'b0;
    if (!w_overrun) begin
      if (w_start) begin
        w_tmr_load = 1'b1;
        w_tmr_val  = CNT_W'(ACK_TIMEOUT - 1);
      end else begin
        case (r_state)
          REQ: begin
            if (!r_req) begin
              w_tmr_load = 1'b1;
              w_tmr_val  = CNT_W'(ACK_TIMEOUT - 1);
            end else if (data_ack) begin
              w_tmr_load = 1'b1;
              w_tmr_val  = CNT_W'(DEAD_CYCLES - 1);
            end else begin
              w_tmr_dec = 1'b1;
            end
          end
          BLANK: begin
            if (w_done) begin
              w_tmr_load = 1'b1;
              w_tmr_val  = CNT_W'(DRIVE_CYCLES - 1);
            end else begin
              w_tmr_dec = 1'b1;
            end
          end
          DRIVE: begin
            if (w_done) begin
              w_tmr_load = 1'b1;
              w_tmr_val  = CNT_W'(ACK_TIMEOUT - 1);
            end else begin
              w_tmr_dec = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk       (clk_33),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_dec     (w_tmr_dec),
    .o_done_c  (w_done)
  );

  always_ff @(posedge clk_33) begin
    if (rst) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_mux         <= '0;
      r_req         <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_ack_timeout <= 1'b0;
    end else begin
      r_overrun     <= 1'b0;
      r_ack_timeout <= 1'b0;
      if (w_overrun) begin
        r_state   <= REQ;
        r_col     <= '0;
        r_mux     <= '0;
        r_req     <= 1'b0;
        r_busy    <= 1'b1;
        r_overrun <= 1'b1;
      end else if (w_start) begin
        r_state <= REQ;
        r_col   <= '0;
        r_mux   <= '0;
        r_req   <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          REQ: begin
            if (!r_req) begin
              r_req <= 1'b1;
            end else if (data_ack) begin
              r_req   <= 1'b0;
              r_state <= BLANK;
            end else if (w_done) begin
              r_req         <= 1'b0;
              r_ack_timeout <= 1'b1;
              if (w_last) begin
                r_state <= IDLE;
                r_col   <= '0;
                r_busy  <= 1'b0;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
          BLANK: begin
            if (w_done) begin
              r_state <= DRIVE;
              r_mux   <= NB_COLS'(1) << r_col;
            end
          end
          DRIVE: begin
            if (w_done) begin
              r_mux <= '0;
              if (w_last) begin
                r_state <= IDLE;
                r_col   <= '0;
                r_busy  <= 1'b0;
              end else begin
                r_state <= REQ;
                r_col   <= r_col + COL_W'(1);
                r_req   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_req    = r_req;
  assign col_idx     = r_col;
  assign mux_out     = r_mux;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign ack_timeout = r_ack_timeout;

endmodule
